branch_hazard_unit: RTL and testbench
=====================================

BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter NSRC, default 2, number of branch source operands checked (rs, rt, ...).
REQ-003 SHALL have parameter EX_FWD, default 1: 1 = forward ALU result from EX stage; 0 = stall one cycle instead.
REQ-004 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have the following ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_branch  in  1  branch/compare instruction in ID
- id_src  in  NSRC*AW  source register addresses; slice i = [i*AW +: AW]
- ex_regwrite, ex_memread  in  1 each  EX-stage producer writes register / is a load
- ex_rd  in  AW  EX-stage destination
- mem_regwrite, mem_memread  in  1 each  MEM-stage equivalents
- mem_rd  in  AW  MEM-stage destination
- wb_regwrite  in  1  WB-stage write enable
- wb_rd  in  AW  WB-stage destination
- br_taken  in  1  branch resolved taken in ID
- cnt_clr  in  1  synchronous clear of both counters
- fwd_sel  out  2*NSRC  per-source select, slice i = [2i +: 2]: 00 regfile, 01 EX ALU result, 10 EX/MEM ALU result, 11 WB write data
- stall  out  1  hold PC and IF/ID, bubble into EX
- if_flush  out  1  flush IF/ID
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Function
REQ-007 A source i SHALL match a stage only when that stage's regwrite=1, its rd!=0, and rd equals source i; no output is affected when id_branch=0.
REQ-008 Per-source need: EX load match = 2; EX non-load match = 0 if EX_FWD=1, else 1; otherwise MEM load match = 1; otherwise 0. EX SHALL take priority over MEM, and MEM over WB.
REQ-009 need_max SHALL be the maximum need over all NSRC sources.
REQ-010 FSM states SHALL be IDLE and STALL, with a registered remaining-count rem (2 bits).
REQ-011 IDLE: stall = (need_max>0), combinationally in the same cycle. need_max=2 -> go to STALL with rem=1. need_max<=1 -> stay in IDLE.
REQ-012 STALL: stall=1 regardless of inputs; rem decrements; go to IDLE when rem reaches 0. The worst case is exactly 2 consecutive stall cycles per hazard.
REQ-013 When stall=0 and id_branch=1, fwd_sel[i] SHALL be:
- 01 on an EX non-load match (EX_FWD=1)
- else 10 on a MEM non-load match
- else 11 on a WB match
- else 00
REQ-014 When stall=1 or id_branch=0, fwd_sel SHALL be all zeros.
REQ-015 if_flush SHALL equal id_branch & br_taken & ~stall, combinationally; a taken branch under stall SHALL NOT flush.
REQ-016 stall_cnt SHALL increment on each clock with stall=1; flush_cnt SHALL increment on each clock with if_flush=1.
REQ-017 Both counters SHALL saturate at all-ones with no wrap-around.
REQ-018 cnt_clr=1 SHALL zero both counters on the next edge, with priority over a simultaneous increment.
REQ-019 All sources matching the same stage simultaneously SHALL each receive that stage's select; a simultaneous EX and MEM match SHALL select EX.

Reset
REQ-020 rst_n=0 SHALL immediately force state=IDLE, rem=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-021 Reset asserted mid-STALL SHALL abandon the remaining stall; after release, stall SHALL be recomputed from the inputs alone.
REQ-022 During reset, the combinational outputs (fwd_sel, if_flush) SHALL follow REQ-013..REQ-015, with the FSM held in IDLE.

Verification
REQ-023 EX_FWD=1, id_branch=1, id_src[0]=8, ex_regwrite=1, ex_memread=0, ex_rd=8 -> stall=0, fwd_sel=2'b01 on source 0, 00 on source 1.
REQ-024 EX load ex_rd=9 = id_src[1], with the pipeline advancing the load to MEM then WB -> stall=1 for exactly 2 cycles, then fwd_sel[1]=11, stall_cnt=2.
REQ-025 ex_rd=0 with regwrite=1 matching id_src=0 -> no stall, fwd_sel=0; EX_FWD=0 with an EX ALU match on rd 5 -> 1 stall cycle, then fwd_sel=10.
REQ-026 br_taken=1 during a stall cycle -> if_flush=0; on the following non-stall cycle -> if_flush=1, flush_cnt+1.
REQ-027 CNT_W=2, 5 consecutive stall cycles -> stall_cnt holds 3; cnt_clr asserted while stall=1 -> stall_cnt=0.
REQ-028 rst_n pulsed low during the second cycle of a 2-cycle stall -> stall drops asynchronously, counters=0, state=IDLE.

Source files
------------

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: ID-stage branch operand forwarding, stall FSM and event counters
module branch_hazard_unit #(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int EX_FWD = 1,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_branch,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic                 ex_regwrite,
  input  logic                 ex_memread,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 mem_regwrite,
  input  logic                 mem_memread,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 wb_regwrite,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 br_taken,
  input  logic                 cnt_clr,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 if_flush,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state, state_n;
  logic [1:0] rem, rem_n;
  logic [1:0] need [NSRC];
  logic [1:0] need_max;
  logic [2*NSRC-1:0] sel;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] s;
    logic ex_m, mem_m, wb_m;
    assign s     = id_src[i*AW +: AW];
    assign ex_m  = id_branch && ex_regwrite && ex_rd != '0 && ex_rd == s;
    assign mem_m = id_branch && mem_regwrite && mem_rd != '0 && mem_rd == s;
    assign wb_m  = id_branch && wb_regwrite && wb_rd != '0 && wb_rd == s;
    assign need[i] = ex_m ? (ex_memread ? 2'd2 : (EX_FWD != 0 ? 2'd0 : 2'd1))
                   : (mem_m && mem_memread) ? 2'd1 : 2'd0;
    assign sel[2*i +: 2] = (ex_m && !ex_memread && EX_FWD != 0) ? 2'b01
                         : (mem_m && !mem_memread) ? 2'b10
                         : wb_m ? 2'b11 : 2'b00;
  end
  always_comb begin
    need_max = '0;
    for (int k = 0; k < NSRC; k++) need_max = (need[k] > need_max) ? need[k] : need_max;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end
  // a load-use hazard costs the IDLE cycle plus rem cycles in STALL
  always_comb begin
    state_n = (state == STALL) ? ((rem <= 2'd1) ? IDLE : STALL)
                               : ((need_max == 2'd2) ? STALL : IDLE);
    rem_n   = (state == STALL) ? ((rem != 2'd0) ? rem - 2'd1 : 2'd0)
                               : ((need_max == 2'd2) ? 2'd1 : 2'd0);
  end
  always_comb begin
    stall    = (state == STALL) || (need_max != 2'd0);
    fwd_sel  = stall ? '0 : sel;
    if_flush = id_branch && br_taken && !stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (if_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb_branch_hazard_unit: directed checks on a default instance and an EX_FWD=0, CNT_W=2 instance
module tb_branch_hazard_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_branch, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, br_taken, cnt_clr;
  logic [9:0] id_src;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [3:0] fwd_a, fwd_b;
  logic stall_a, stall_b, flush_a, flush_b;
  logic [15:0] sc_a, fc_a;
  logic [1:0] sc_b, fc_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_src(id_src),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .br_taken(br_taken), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_a), .stall(stall_a), .if_flush(flush_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );
  branch_hazard_unit #(.EX_FWD(0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .id_src(id_src),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .br_taken(br_taken), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_b), .stall(stall_b), .if_flush(flush_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr_in();
    {id_branch, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, br_taken, cnt_clr} = '0;
    id_src = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr_in();
    #3;
    chk("rst_stall", stall_a, 0);
    chk("rst_sc_a", sc_a, 0);
    chk("rst_fc_a", fc_a, 0);
    chk("rst_sc_b", sc_b, 0);
    #9 rst_n = 1'b1;
    tick();
    id_branch = 1; id_src = {5'd3, 5'd8}; ex_regwrite = 1; ex_rd = 8;
    #2;
    chk("ex_fwd_stall", stall_a, 0);
    chk("ex_fwd_sel", fwd_a, 4'b0001);
    chk("ex_fwd_flush", flush_a, 0);
    chk("nofwd_stall_b", stall_b, 1);
    tick();
    clr_in(); id_branch = 1; ex_regwrite = 1; ex_rd = 0; id_src = '0;
    #2;
    chk("rd0_stall", stall_a, 0);
    chk("rd0_sel", fwd_a, 0);
    chk("rd0_stall_b", stall_b, 0);
    tick();
    clr_in(); cnt_clr = 1;
    tick();
    chk("clr_sc_a", sc_a, 0);
    clr_in(); id_branch = 1; id_src = {5'd9, 5'd2}; ex_regwrite = 1; ex_memread = 1; ex_rd = 9;
    #2;
    chk("ld_c1_stall", stall_a, 1);
    chk("ld_c1_sel", fwd_a, 0);
    tick();
    chk("ld_sc1", sc_a, 1);
    clr_in(); id_branch = 1; id_src = {5'd9, 5'd2}; mem_regwrite = 1; mem_memread = 1; mem_rd = 9;
    #2;
    chk("ld_c2_stall", stall_a, 1);
    chk("ld_c2_sel", fwd_a, 0);
    tick();
    clr_in(); id_branch = 1; id_src = {5'd9, 5'd2}; wb_regwrite = 1; wb_rd = 9;
    #2;
    chk("ld_c3_stall", stall_a, 0);
    chk("ld_c3_sel", fwd_a, 4'b1100);
    tick();
    chk("ld_sc2", sc_a, 2);
    clr_in(); id_branch = 1; id_src = {5'd1, 5'd5}; ex_regwrite = 1; ex_rd = 5;
    #2;
    chk("alu_b_stall", stall_b, 1);
    chk("alu_b_sel", fwd_b, 0);
    chk("alu_a_sel", fwd_a, 4'b0001);
    tick();
    clr_in(); id_branch = 1; id_src = {5'd1, 5'd5}; mem_regwrite = 1; mem_rd = 5;
    #2;
    chk("alu_b_stall2", stall_b, 0);
    chk("alu_b_mem_sel", fwd_b, 4'b0010);
    chk("alu_a_mem_sel", fwd_a, 4'b0010);
    tick();
    clr_in(); id_branch = 1; br_taken = 1; id_src = {5'd0, 5'd7}; ex_regwrite = 1; ex_memread = 1; ex_rd = 7;
    #2;
    chk("br_c1_flush", flush_a, 0);
    chk("br_c1_stall", stall_a, 1);
    tick();
    clr_in(); id_branch = 1; br_taken = 1; id_src = {5'd0, 5'd7}; mem_regwrite = 1; mem_memread = 1; mem_rd = 7;
    #2;
    chk("br_c2_flush", flush_a, 0);
    tick();
    clr_in(); id_branch = 1; br_taken = 1; id_src = {5'd0, 5'd7}; wb_regwrite = 1; wb_rd = 7;
    #2;
    chk("br_c3_flush", flush_a, 1);
    chk("br_c3_sel", fwd_a, 4'b0011);
    tick();
    clr_in();
    #2;
    chk("br_fc", fc_a, 1);
    chk("br_sc", sc_a, 4);
    clr_in(); id_branch = 1; id_src = {5'd10, 5'd10}; ex_regwrite = 1; ex_rd = 10; mem_regwrite = 1; mem_rd = 10;
    #2;
    chk("both_ex_mem_sel", fwd_a, 4'b0101);
    clr_in(); id_branch = 0; id_src = {5'd0, 5'd6}; ex_regwrite = 1; ex_memread = 1; ex_rd = 6; br_taken = 1;
    #2;
    chk("nobr_stall", stall_a, 0);
    chk("nobr_flush", flush_a, 0);
    tick();
    clr_in(); id_branch = 1; id_src = {5'd0, 5'd6}; ex_regwrite = 1; ex_memread = 1; ex_rd = 6;
    #2;
    chk("rs_c1_stall", stall_a, 1);
    tick();
    clr_in(); id_branch = 1; id_src = {5'd0, 5'd6};
    #2;
    chk("rs_c2_stall", stall_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_async_stall", stall_a, 0);
    chk("rs_async_sc", sc_a, 0);
    chk("rs_async_fc", fc_a, 0);
    wb_regwrite = 1; wb_rd = 6; br_taken = 1;
    #1;
    chk("rs_fwd", fwd_a, 4'b0011);
    chk("rs_flush", flush_a, 1);
    br_taken = 0;
    #1 rst_n = 1'b1;
    tick();
    chk("rs_post_stall", stall_a, 0);
    chk("rs_post_sc", sc_a, 0);
    chk("rs_post_fc", fc_a, 0);
    clr_in(); cnt_clr = 1;
    tick();
    clr_in(); id_branch = 1; id_src = {5'd0, 5'd4}; ex_regwrite = 1; ex_rd = 4;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("sat_stall_b", stall_b, 1);
      tick();
    end
    chk("sat_sc_b", sc_b, 3);
    chk("sat_sc_a", sc_a, 0);
    cnt_clr = 1;
    #1;
    chk("sat_clr_stall_b", stall_b, 1);
    tick();
    chk("sat_clr_sc_b", sc_b, 0);
    clr_in();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
